// File: rtl/axi_qos_rr_arbiter_pkg.sv
// Shared types and the round-robin search helper for the QoS address-channel arbiter.
// Optional aging support lives in the top module behind AXI_ARB_AGING_EN.
package axi_arb_pkg;

    typedef enum logic {IDLE, HOLD} arb_state_e;

    localparam int ARB_MAX_N = 32;

    // First set bit of mask at ptr+1, ptr+2, ... (mod n); 0 when mask is empty.
    function automatic logic [4:0] rr_pick(input logic [ARB_MAX_N-1:0] mask,
                                           input logic [4:0]           ptr,
                                           input int                   n);
        logic [5:0] idx;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= ARB_MAX_N; k++) begin
            if (k <= n && !found) begin
                idx = {1'b0, ptr} + 6'(k);
                if (idx >= 6'(n)) idx = idx - 6'(n);
                if (mask[idx[4:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx[4:0];
                end
            end
        end
    endfunction

endpackage

// File: rtl/axi_qos_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: per-requester valid/QoS/grant plus the shared slave handshake.
// slave = arbiter view, master = requesters/slave-channel view.
interface axi_qos_rr_arbiter_if #(
    parameter int N_REQ     = 8,
    parameter int QOS_W     = 4,
    parameter int LOG_N_REQ = $clog2(N_REQ)
);
    logic [N_REQ-1:0]             req_i;
    logic [N_REQ-1:0][QOS_W-1:0]  qos_i;
    logic [N_REQ-1:0]             gnt_o;
    logic [LOG_N_REQ-1:0]         gnt_idx_o;
    logic                         valid_o;
    logic                         ready_i;

    modport slave  (input  req_i, qos_i, ready_i, output gnt_o, gnt_idx_o, valid_o);
    modport master (output req_i, qos_i, ready_i, input  gnt_o, gnt_idx_o, valid_o);
endinterface

// File: rtl/axi_qos_rr_arbiter_rr_pick.sv
// Combinational masked round-robin priority encoder, shared by the AW and AR arbiter instances.
module axi_rr_pick
    import axi_arb_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int LOG_N_REQ = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]     mask_i,
    input  logic [LOG_N_REQ-1:0] ptr_i,
    output logic [LOG_N_REQ-1:0] idx_o,
    output logic                 found_o
);
    logic [ARB_MAX_N-1:0] mask_ext;
    logic [4:0]           pick;

    assign mask_ext = ARB_MAX_N'(mask_i);
    assign pick     = rr_pick(mask_ext, 5'(ptr_i), N_REQ);
    assign idx_o    = LOG_N_REQ'(pick);
    assign found_o  = |mask_i;
endmodule

// File: rtl/axi_qos_rr_arbiter.sv
// QoS + round-robin arbiter for one slave-side AXI address channel; grant is locked from valid to handshake.
// Define AXI_ARB_AGING_EN to add per-requester aging counters that promote starved requesters to urgent.
module axi_qos_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_REQ      = 8,
    parameter int LOG_N_REQ  = $clog2(N_REQ),
    parameter int QOS_W      = 4,
    parameter int AGE_W      = 4,
    parameter int AGE_THRESH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_qos_rr_arbiter_if.slave    bus
);
    arb_state_e           state_q, state_d;
    logic [LOG_N_REQ-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_N_REQ-1:0] lock_idx_q, lock_idx_d;
    logic [LOG_N_REQ-1:0] pick_idx;
    logic                 pick_found;
    logic [N_REQ-1:0]     elig;
    logic [N_REQ-1:0]     urgent;
    logic [QOS_W-1:0]     max_qos;
    logic [N_REQ-1:0]     gnt;
    logic [LOG_N_REQ-1:0] gnt_idx;
    logic                 valid;

`ifdef AXI_ARB_AGING_EN
    logic [N_REQ-1:0][AGE_W-1:0] age_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_i[i] || gnt[i])
                    age_q[i] <= '0;
                else if (age_q[i] != {AGE_W{1'b1}})
                    age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        urgent = '0;
        for (int i = 0; i < N_REQ; i++)
            urgent[i] = bus.req_i[i] && (age_q[i] >= AGE_W'(AGE_THRESH));
    end
`else
    logic unused_age_cfg;
    assign urgent         = '0;
    assign unused_age_cfg = (AGE_W > 0) && (AGE_THRESH > 0);
`endif

    // Urgent requesters bypass QoS entirely and share plain round-robin.
    always_comb begin
        max_qos = '0;
        elig    = '0;
        for (int i = 0; i < N_REQ; i++)
            if (bus.req_i[i] && bus.qos_i[i] > max_qos) max_qos = bus.qos_i[i];
        for (int i = 0; i < N_REQ; i++)
            elig[i] = bus.req_i[i] && (bus.qos_i[i] == max_qos);
        if (|urgent) elig = urgent;
    end

    axi_rr_pick #(.N_REQ(N_REQ), .LOG_N_REQ(LOG_N_REQ)) u_pick (
        .mask_i  (elig),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= LOG_N_REQ'(N_REQ - 1);
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        valid      = 1'b0;
        gnt        = '0;
        gnt_idx    = pick_idx;
        unique case (state_q)
            IDLE: begin
                valid = pick_found;
                if (pick_found) begin
                    if (bus.ready_i) begin
                        gnt[pick_idx] = 1'b1;
                        rr_ptr_d      = pick_idx;
                    end else begin
                        lock_idx_d = pick_idx;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                gnt_idx = lock_idx_q;
                valid   = bus.req_i[lock_idx_q];
                if (!valid) begin
                    state_d = IDLE;
                end else if (bus.ready_i) begin
                    gnt[lock_idx_q] = 1'b1;
                    rr_ptr_d        = lock_idx_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even if requests are already present.
    assign bus.valid_o   = valid & rst_n;
    assign bus.gnt_o     = rst_n ? gnt : '0;
    assign bus.gnt_idx_o = rst_n ? gnt_idx : '0;
endmodule

// File: tb/tb_axi_qos_rr_arbiter.sv
// Scoreboard bench for axi_qos_rr_arbiter: expected per-cycle valid/grant/index queued at drive time.
module tb_axi_qos_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        string      tag;
        logic       valid;
        logic [7:0] gnt;
        logic [2:0] idx;
        bit         chk_idx;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    axi_qos_rr_arbiter_if #(.N_REQ(8), .QOS_W(4)) bus ();

    axi_qos_rr_arbiter #(.N_REQ(8), .QOS_W(4), .AGE_W(4), .AGE_THRESH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] req, input logic rdy);
        bus.req_i   = req;
        bus.ready_i = rdy;
    endtask

    task automatic clr_qos();
        for (int i = 0; i < 8; i++) bus.qos_i[i] = 4'd0;
    endtask

    task automatic push(input string tag, input logic v, input logic [7:0] g,
                        input logic [2:0] idx, input bit ci);
        exp_t e;
        e.tag = tag; e.valid = v; e.gnt = g; e.idx = idx; e.chk_idx = ci;
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty got=0 entries exp=1 entry");
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_valid"}, 32'(bus.valid_o), 32'(e.valid));
            check({e.tag, "_gnt"},   32'(bus.gnt_o),   32'(e.gnt));
            if (e.chk_idx) check({e.tag, "_idx"}, 32'(bus.gnt_idx_o), 32'(e.idx));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(8'h00, 1'b0);
        clr_qos();
        #12;
        check("rst_valid", 32'(bus.valid_o),   32'd0);
        check("rst_gnt",   32'(bus.gnt_o),     32'd0);
        check("rst_idx",   32'(bus.gnt_idx_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all requesting, equal QoS: strict rotation from requester 0
        drive(8'hFF, 1'b1);
        for (int k = 0; k < 9; k++) begin
            push($sformatf("t1_c%0d", k), 1'b1, 8'h01 << (k % 8), 3'(k % 8), 1'b1);
            step();
        end

        // higher QoS wins every cycle
        drive(8'h24, 1'b1);
        bus.qos_i[2] = 4'd3;
        bus.qos_i[5] = 4'd9;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("t2_c%0d", k), 1'b1, 8'h20, 3'd5, 1'b1);
            step();
        end
        clr_qos();

        // locked grant survives a QoS change while ready is low
        drive(8'h03, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) bus.qos_i[1] = 4'd5;
            push($sformatf("t3_hold%0d", k), 1'b1, 8'h00, 3'd0, 1'b1);
            step();
        end
        bus.ready_i = 1'b1;
        push("t3_rel", 1'b1, 8'h01, 3'd0, 1'b1);
        step();
        push("t3_next", 1'b1, 8'h02, 3'd1, 1'b1);
        step();
        drive(8'h00, 1'b0);
        clr_qos();
        push("t3_quiet", 1'b0, 8'h00, 3'd0, 1'b0);
        step();

        // lock on 3, requester drops: no grant, back to IDLE, pointer untouched
        for (int pass = 0; pass < 2; pass++) begin
            drive(8'h04, 1'b1);
            push($sformatf("t4p%0d_pre", pass), 1'b1, 8'h04, 3'd2, 1'b1);
            step();
            drive(8'h08, 1'b0);
            push($sformatf("t4p%0d_lock", pass), 1'b1, 8'h00, 3'd3, 1'b1);
            step();
            drive(8'h00, 1'b1);
            push($sformatf("t4p%0d_drop", pass), 1'b0, 8'h00, 3'd3, 1'b1);
            step();
            if (pass == 0) begin
                drive(8'hF7, 1'b1);
                push("t4p0_idle", 1'b1, 8'h10, 3'd4, 1'b1);
            end else begin
                drive(8'h18, 1'b1);
                push("t4p1_ptr", 1'b1, 8'h08, 3'd3, 1'b1);
            end
            step();
        end

        // starvation of requester 0 by a QoS-15 neighbour
        drive(8'h03, 1'b1);
        bus.qos_i[0] = 4'd0;
        bus.qos_i[1] = 4'd15;
        for (int k = 1; k <= 16; k++) begin
            logic [2:0] w;
`ifdef AXI_ARB_AGING_EN
            w = (k == 13) ? 3'd0 : 3'd1;
`else
            w = 3'd1;
`endif
            push($sformatf("t5_c%0d", k), 1'b1, 8'h01 << w, w, 1'b1);
            step();
        end
        drive(8'h00, 1'b0);
        clr_qos();
        push("t5_quiet", 1'b0, 8'h00, 3'd0, 1'b0);
        step();

        // asynchronous reset while locked
        drive(8'h08, 1'b0);
        push("t6_lock", 1'b1, 8'h00, 3'd3, 1'b1);
        step();
        bus.ready_i = 1'b1;
        #1;
        check("t6_hold_gnt", 32'(bus.gnt_o), 32'h08);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.valid_o),   32'd0);
        check("t6_rst_gnt",   32'(bus.gnt_o),     32'd0);
        check("t6_rst_idx",   32'(bus.gnt_idx_o), 32'd0);
        drive(8'h00, 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(8'hFF, 1'b1);
        push("t6_first", 1'b1, 8'h01, 3'd0, 1'b1);
        step();
        push("t6_second", 1'b1, 8'h02, 3'd1, 1'b1);
        step();

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got=%0d entries exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
